mdio_generator: RTL and testbench

//   Clause-22 MDIO management master (STA). Serialises a 32-bit management frame on MDIO/MDC.

---
 rtl/mdio_generator.sv | 181 ++++++++++++++++++
 tb/tb_mdio_generator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdio_generator.sv
// Clause-22 MDIO management master: serialises a 32-bit frame on MDC/MDIO and captures read data.
// Optional MDIO_PREAMBLE_EN: prepend 32 MDC periods of mdio_out=1 before the frame.
module mdio_generator #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        data_rdy
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned PH_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = 5;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(31);
  localparam logic [BIT_W-1:0] LAST_DRV = BIT_W'(13);
  localparam logic [BIT_W-1:0] LAST_TA  = BIT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MDIO_PREAMBLE_EN
    S_PREAMBLE,
`endif
    S_SEND,
    S_TA,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PH_W-1:0]   phase, phase_nxt, phase_step;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic [15:0]       rx_shreg, rx_nxt;
  logic              op_rd, op_rd_nxt;
  logic              mdc_nxt, out_nxt, oe_nxt, rdy_nxt;
  logic [15:0]       rd_data_nxt;
  logic              bit_end, sample_pt;

  assign bit_end    = (phase == PH_W'(CLK_DIV - 1));
  assign sample_pt  = (phase == PH_W'(HALF - 1));
  assign phase_step = bit_end ? '0 : phase + PH_W'(1);

  // State, counters and all outputs registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_shreg <= '0;
      op_rd    <= 1'b0;
      mdc      <= 1'b0;
      mdio_out <= 1'b0;
      mdio_oe  <= 1'b0;
      rd_data  <= '0;
      data_rdy <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      rx_shreg <= rx_nxt;
      op_rd    <= op_rd_nxt;
      mdc      <= mdc_nxt;
      mdio_out <= out_nxt;
      mdio_oe  <= oe_nxt;
      rd_data  <= rd_data_nxt;
      data_rdy <= rdy_nxt;
    end
  end

  // Next-state and next-output logic; mdio_out/mdio_oe only move at bit boundaries
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    rx_nxt      = rx_shreg;
    op_rd_nxt   = op_rd;
    out_nxt     = mdio_out;
    oe_nxt      = mdio_oe;
    rd_data_nxt = rd_data;
    rdy_nxt     = 1'b0;
    mdc_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        phase_nxt = '0;
        out_nxt   = 1'b0;
        oe_nxt    = 1'b0;
        if (mdio_start) begin
          bit_nxt   = '0;
          rx_nxt    = '0;
          op_rd_nxt = (t_data[29:28] == 2'b10);
          oe_nxt    = 1'b1;
`ifdef MDIO_PREAMBLE_EN
          state_nxt = S_PREAMBLE;
          shreg_nxt = t_data;
          out_nxt   = 1'b1;
`else
          state_nxt = S_SEND;
          shreg_nxt = {t_data[30:0], 1'b0};
          out_nxt   = t_data[31];
`endif
        end
      end
`ifdef MDIO_PREAMBLE_EN
      S_PREAMBLE: begin
        phase_nxt = phase_step;
        if (bit_end) begin
          bit_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_SEND;
            out_nxt   = shreg[31];
            shreg_nxt = {shreg[30:0], 1'b0};
          end
        end
      end
`endif
      S_SEND: begin
        phase_nxt = phase_step;
        if (bit_end) begin
          bit_nxt   = bit_cnt + BIT_W'(1);
          out_nxt   = shreg[31];
          shreg_nxt = {shreg[30:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_DONE;
            out_nxt   = 1'b0;
            oe_nxt    = 1'b0;
          end else if (op_rd && (bit_cnt == LAST_DRV)) begin
            state_nxt = S_TA;
            out_nxt   = 1'b0;
            oe_nxt    = 1'b0;
          end
        end
      end
      S_TA: begin
        phase_nxt = phase_step;
        if (bit_end) begin
          bit_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_TA) state_nxt = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        phase_nxt = phase_step;
        // PHY data is sampled on the edge where mdc rises
        if (sample_pt) rx_nxt = {rx_shreg[14:0], mdio_in};
        if (bit_end) begin
          bit_nxt = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_nxt   = S_DONE;
            rd_data_nxt = rx_shreg;
            rdy_nxt     = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
        out_nxt   = 1'b0;
        oe_nxt    = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        phase_nxt = '0;
        out_nxt   = 1'b0;
        oe_nxt    = 1'b0;
      end
    endcase

    mdc_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (phase_nxt >= PH_W'(HALF));
  end

endmodule

// File: tb/tb_mdio_generator.sv
// Directed self-checking bench for mdio_generator with a simple PHY read-data model.
`timescale 1ns/1ps
module tb_mdio_generator;

  localparam int unsigned CLK_DIV = 2;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
  localparam logic [31:0] PRE_WORD = 32'hFFFF_FFFF;
`else
  localparam int PRE = 0;
  localparam logic [31:0] PRE_WORD = 32'h0;
`endif
  localparam int FR  = 32 + PRE;
  localparam int WIN = FR * CLK_DIV + 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdio_start = 1'b0;
  logic        mdio_in = 1'b0;
  logic [31:0] t_data = '0;
  logic        mdc, mdio_out, mdio_oe, data_rdy;
  logic [15:0] rd_data;

  int errors = 0;
  int checks = 0;

  logic [63:0] cap_out, cap_oe;
  int          n_mdc, rdy_cnt, rdy_at_n;
  logic [15:0] rdy_val;
  logic        first_out, first_oe, rst_bad;

  logic [15:0] phy_data = '0;
  logic        phy_clr = 1'b0;
  int          phy_cnt = 0;

  always #5 clk = ~clk;

  mdio_generator #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .mdio_start(mdio_start), .t_data(t_data),
    .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe), .mdio_in(mdio_in),
    .rd_data(rd_data), .data_rdy(data_rdy)
  );

  // PHY model: counts MDC periods, drives read data MSB first after each MDC fall
  always @(posedge mdc or posedge phy_clr) begin
    if (phy_clr) phy_cnt = 0;
    else         phy_cnt = phy_cnt + 1;
  end

  always @(negedge mdc) begin
    if (phy_cnt >= PRE + 16 && phy_cnt < PRE + 32)
      mdio_in = phy_data[4'(PRE + 31 - phy_cnt)];
  end

  task automatic run_frame(input logic [31:0] td, input logic [15:0] phy,
                           input int mid_bit, input int rst_bit);
    logic prev;
    logic mid_done, rst_done;
    int   rst_left;
    cap_out = '0; cap_oe = '0; n_mdc = 0; rdy_cnt = 0; rdy_at_n = -1; rdy_val = '0;
    rst_bad = 1'b0; mid_done = 1'b0; rst_done = 1'b0; rst_left = 0;
    phy_data = phy;
    phy_clr = 1'b1; #1; phy_clr = 1'b0;
    t_data = td;
    mdio_start = 1'b1;
    @(negedge clk);
    mdio_start = 1'b0;
    first_out = mdio_out;
    first_oe  = mdio_oe;
    prev = mdc;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      if (!reset && (mdc || mdio_out || mdio_oe || data_rdy || rd_data != 16'h0)) rst_bad = 1'b1;
      if (mdc && !prev) begin
        cap_out = {cap_out[62:0], mdio_out};
        cap_oe  = {cap_oe[62:0], mdio_oe};
        n_mdc++;
      end
      prev = mdc;
      if (data_rdy) begin
        rdy_cnt++;
        rdy_val  = rd_data;
        rdy_at_n = n_mdc;
      end
      mdio_start = (n_mdc == mid_bit) && !mid_done;
      if (mdio_start) begin
        mid_done = 1'b1;
        t_data   = ~td;
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b1;
      end else if (n_mdc == rst_bit && !rst_done) begin
        reset    = 1'b0;
        rst_done = 1'b1;
        rst_left = 3;
      end
    end
    mdio_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mdc !== 1'b0) begin errors++; $display("FAIL reset_mdc: got %b expected 0", mdc); end
    checks++; if (mdio_out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", mdio_out); end
    checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", mdio_oe); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    checks++; if (data_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", data_rdy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic exp_first;
    exp_first = (PRE > 0) ? 1'b1 : 1'b0;  // bit 31 of 0x5A3CBEEF is 0
    run_frame(32'h5A3C_BEEF, 16'h0, 999, 999);
    checks++; if (first_out !== exp_first) begin errors++; $display("FAIL wr_first_bit: got %b expected %b", first_out, exp_first); end
    checks++; if (first_oe !== 1'b1) begin errors++; $display("FAIL wr_first_oe: got %b expected 1", first_oe); end
    checks++; if (cap_out !== {PRE_WORD, 32'h5A3C_BEEF}) begin errors++; $display("FAIL wr_bits: got %h expected %h", cap_out, {PRE_WORD, 32'h5A3C_BEEF}); end
    checks++; if (cap_oe !== {PRE_WORD, 32'hFFFF_FFFF}) begin errors++; $display("FAIL wr_oe: got %h expected %h", cap_oe, {PRE_WORD, 32'hFFFF_FFFF}); end
    checks++; if (n_mdc !== FR) begin errors++; $display("FAIL wr_mdc_count: got %0d expected %0d", n_mdc, FR); end
    checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL wr_no_rdy: got %0d pulses expected 0", rdy_cnt); end
  endtask

  task automatic test_read();
    run_frame(32'h6A3E_0000, 16'hC0DE, 999, 999);
    checks++; if (cap_oe !== {PRE_WORD, 32'hFFFC_0000}) begin errors++; $display("FAIL rd_oe: got %h expected %h", cap_oe, {PRE_WORD, 32'hFFFC_0000}); end
    checks++; if ((cap_out & {32'hFFFF_FFFF, 32'hFFFC_0000}) !== {PRE_WORD, 32'h6A3C_0000}) begin errors++; $display("FAIL rd_hdr_bits: got %h expected %h", cap_out & {32'hFFFF_FFFF, 32'hFFFC_0000}, {PRE_WORD, 32'h6A3C_0000}); end
    checks++; if (n_mdc !== FR) begin errors++; $display("FAIL rd_mdc_count: got %0d expected %0d", n_mdc, FR); end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL rd_rdy_pulses: got %0d expected 1", rdy_cnt); end
    checks++; if (rdy_val !== 16'hC0DE) begin errors++; $display("FAIL rd_data_at_rdy: got %h expected c0de", rdy_val); end
    checks++; if (rdy_at_n !== FR) begin errors++; $display("FAIL rd_rdy_timing: got after %0d mdc expected %0d", rdy_at_n, FR); end
    checks++; if (rd_data !== 16'hC0DE) begin errors++; $display("FAIL rd_data_hold: got %h expected c0de", rd_data); end
  endtask

  task automatic test_start_ignored();
    run_frame(32'h5123_4567, 16'h0, 10, 999);
    checks++; if (cap_out !== {PRE_WORD, 32'h5123_4567}) begin errors++; $display("FAIL mid_start_bits: got %h expected %h", cap_out, {PRE_WORD, 32'h5123_4567}); end
    checks++; if (n_mdc !== FR) begin errors++; $display("FAIL mid_start_count: got %0d expected %0d", n_mdc, FR); end
    checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL mid_start_rdy: got %0d expected 0", rdy_cnt); end
    checks++; if (rd_data !== 16'hC0DE) begin errors++; $display("FAIL wr_keeps_rd_data: got %h expected c0de", rd_data); end
  endtask

  task automatic test_reset_mid_read();
    run_frame(32'h6A3E_0000, 16'hA5A5, 999, PRE + 20);
    checks++; if (rst_bad !== 1'b0) begin errors++; $display("FAIL mid_rst_outputs: got nonzero output expected all 0"); end
    checks++; if (n_mdc !== PRE + 20) begin errors++; $display("FAIL mid_rst_count: got %0d expected %0d", n_mdc, PRE + 20); end
    checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL mid_rst_rdy: got %0d expected 0", rdy_cnt); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL mid_rst_rd_data: got %h expected 0000", rd_data); end
    checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_oe_after: got %b expected 0", mdio_oe); end
  endtask

  task automatic test_back_to_back();
    logic        prev;
    logic [63:0] co;
    int          n, gap, last_rise;
    co = '0; n = 0; gap = 0; last_rise = 0;
    t_data = 32'h5A3C_BEEF;
    mdio_start = 1'b1;
    @(negedge clk);
    prev = mdc;
    for (int c = 1; c <= 2 * WIN; c++) begin
      @(negedge clk);
      if (mdc && !prev) begin
        co = {co[62:0], mdio_out};
        n++;
        if (n == FR) t_data = 32'h1234_5678;
        if (n == FR + 1) begin
          gap = c - last_rise;
          mdio_start = 1'b0;
        end
        last_rise = c;
      end
      prev = mdc;
    end
    mdio_start = 1'b0;
    checks++; if (n !== 2 * FR) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", n, 2 * FR); end
    checks++; if (gap !== CLK_DIV + 2) begin errors++; $display("FAIL b2b_gap: got %0d clks expected %0d", gap, CLK_DIV + 2); end
    checks++; if (co[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL b2b_second: got %h expected 12345678", co[31:0]); end
`ifdef MDIO_PREAMBLE_EN
    checks++; if (co[63:32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_preamble: got %h expected ffffffff", co[63:32]); end
`else
    checks++; if (co[63:32] !== 32'h5A3C_BEEF) begin errors++; $display("FAIL b2b_first: got %h expected 5a3cbeef", co[63:32]); end
`endif
  endtask

`ifdef MDIO_PREAMBLE_EN
  task automatic test_preamble();
    run_frame(32'h5000_0001, 16'h0, 999, 999);
    checks++; if (cap_out !== {32'hFFFF_FFFF, 32'h5000_0001}) begin errors++; $display("FAIL pre_bits: got %h expected ffffffff50000001", cap_out); end
    checks++; if (n_mdc !== 64) begin errors++; $display("FAIL pre_count: got %0d expected 64", n_mdc); end
  endtask
`endif

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_start_ignored();
    test_reset_mid_read();
    test_back_to_back();
`ifdef MDIO_PREAMBLE_EN
    test_preamble();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
